// File: rtl/rvfpm_pkg.sv
// Shared types and default widths for the rvfpm issue queue.
package rvfpm_pkg;

  localparam int unsigned IQ_DEF_ID_WIDTH = 4;
  localparam int unsigned IQ_DEF_DEPTH    = 4;
  localparam int unsigned IQ_DEF_XLEN     = 32;

  // Per-entry lifecycle.
  typedef enum logic [1:0] {
    EMPTY,
    PENDING,
    COMMITTED,
    KILLED
  } iq_state_t;

  // One queue slot at the default widths.
  typedef struct packed {
    logic [31:0]                instr;
    logic [IQ_DEF_ID_WIDTH-1:0] id;
    logic [IQ_DEF_XLEN-1:0]     rs1;
    logic [IQ_DEF_XLEN-1:0]     rs2;
    iq_state_t                  state;
  } iq_entry_t;

endpackage

// File: rtl/rvfpm_issue_queue.sv
// Issue queue between the CV-X-IF issue/commit interfaces and the rvfpm
// pipeline. Entries wait as PENDING until committed or killed; committed
// entries leave in program order, killed ones are dropped at the head.
// Optional feature: define RVFPM_IQ_BYPASS_EN to allow same-cycle
// issue+commit to reach out_* combinationally when the queue is empty.
module rvfpm_issue_queue
  import rvfpm_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH  = IQ_DEF_ID_WIDTH,
  parameter int unsigned QUEUE_DEPTH = IQ_DEF_DEPTH,
  parameter int unsigned XLEN        = IQ_DEF_XLEN
) (
  input  logic                               ck,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [31:0]                        in_instr,
  input  logic [X_ID_WIDTH-1:0]              in_id,
  input  logic [XLEN-1:0]                    in_rs1,
  input  logic [XLEN-1:0]                    in_rs2,
  input  logic                               commit_valid,
  input  logic [X_ID_WIDTH-1:0]              commit_id,
  input  logic                               commit_kill,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [31:0]                        out_instr,
  output logic [X_ID_WIDTH-1:0]              out_id,
  output logic [XLEN-1:0]                    out_rs1,
  output logic [XLEN-1:0]                    out_rs2,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count,
  output logic                               empty,
  output logic                               full
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  logic [31:0]           instr_q [QUEUE_DEPTH];
  logic [X_ID_WIDTH-1:0] id_q    [QUEUE_DEPTH];
  logic [XLEN-1:0]       rs1_q   [QUEUE_DEPTH];
  logic [XLEN-1:0]       rs2_q   [QUEUE_DEPTH];
  iq_state_t             state_q [QUEUE_DEPTH];
  iq_state_t             state_d [QUEUE_DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, full_q;

  logic head_commit, push, write, pop, drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign in_ready    = !full_q && !rst;
  assign push        = in_valid && in_ready;
  assign head_commit = (state_q[head_q] == COMMITTED) && !rst;
  assign pop         = head_commit && out_ready;
  assign drop        = (state_q[head_q] == KILLED) && !rst;

`ifdef RVFPM_IQ_BYPASS_EN
  logic bypass;
  assign bypass    = empty_q && in_valid && !rst && commit_valid &&
                     (commit_id == in_id) && !commit_kill;
  assign out_valid = head_commit || bypass;
  assign out_instr = bypass ? in_instr : instr_q[head_q];
  assign out_id    = bypass ? in_id    : id_q[head_q];
  assign out_rs1   = bypass ? in_rs1   : rs1_q[head_q];
  assign out_rs2   = bypass ? in_rs2   : rs2_q[head_q];
  // A bypassed instruction that is accepted never occupies a slot; if the
  // pipeline stalls it is written and the same-cycle commit marks it.
  assign write     = push && !(bypass && out_ready);
`else
  assign out_valid = head_commit;
  assign out_instr = instr_q[head_q];
  assign out_id    = id_q[head_q];
  assign out_rs1   = rs1_q[head_q];
  assign out_rs2   = rs2_q[head_q];
  assign write     = push;
`endif

  assign count = count_q;
  assign empty = empty_q;
  assign full  = full_q;

  // Next entry states: free the head, claim the tail, then apply the commit
  // so an entry written this cycle can be committed in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      state_d[i] = state_q[i];
    end
    if (pop || drop) begin
      state_d[head_q] = EMPTY;
    end
    if (write) begin
      state_d[tail_q] = PENDING;
    end
    if (commit_valid) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        if ((state_d[i] == PENDING) &&
            (((write && (PTR_W'(i) == tail_q)) ? in_id : id_q[i]) == commit_id)) begin
          state_d[i] = commit_kill ? KILLED : COMMITTED;
        end
      end
    end
  end

  // Occupancy after this edge.
  always_comb begin
    count_d = count_q + CNT_W'(write) - CNT_W'(pop || drop);
  end

  // Control state: entry states, pointers and registered status flags.
  always_ff @(posedge ck) begin
    if (rst) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        state_q[i] <= EMPTY;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        state_q[i] <= state_d[i];
      end
      if (write) begin
        tail_q <= ptr_inc(tail_q);
      end
      if (pop || drop) begin
        head_q <= ptr_inc(head_q);
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == FULL_CNT);
    end
  end

  // Payload storage; contents only matter while the slot is non-EMPTY.
  always_ff @(posedge ck) begin
    if (write) begin
      instr_q[tail_q] <= in_instr;
      id_q[tail_q]    <= in_id;
      rs1_q[tail_q]   <= in_rs1;
      rs2_q[tail_q]   <= in_rs2;
    end
  end

endmodule

// File: tb/tb_rvfpm_issue_queue.sv
// Self-checking bench for rvfpm_issue_queue: directed scenarios plus a
// randomized run against a queue-level reference model.
// Honours RVFPM_IQ_BYPASS_EN the same way as the design.
module tb_rvfpm_issue_queue;
  import rvfpm_pkg::*;

  localparam int DEPTH = 4;
`ifdef RVFPM_IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        ck, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_rs1, in_rs2;
  logic [3:0]  in_id;
  logic        commit_valid, commit_kill;
  logic [3:0]  commit_id;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_rs1, out_rs2;
  logic [3:0]  out_id;
  logic [2:0]  count;
  logic        empty, full;

  int checks = 0;
  int errors = 0;

  iq_entry_t  mq[$];        // reference queue contents
  logic [3:0] exp_log[$];   // model dispatch order
  logic [3:0] dut_log[$];   // observed dispatch order

  rvfpm_issue_queue #(.X_ID_WIDTH(4), .QUEUE_DEPTH(DEPTH), .XLEN(32)) dut (
    .ck(ck), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_id(in_id), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_id(out_id), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .count(count), .empty(empty), .full(full)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: applies one clock edge of the queue's rules.
  task automatic model_step();
    bit push, byp, pop, drop, dup;
    iq_entry_t e;
    if (rst) begin
      mq.delete();
      return;
    end
    push = in_valid && (mq.size() < DEPTH);
    byp  = BYP && (mq.size() == 0) && in_valid && commit_valid &&
           (commit_id == in_id) && !commit_kill;
    pop  = (mq.size() > 0) && (mq[0].state == COMMITTED) && out_ready;
    drop = (mq.size() > 0) && (mq[0].state == KILLED);
    if (pop) exp_log.push_back(mq[0].id);
    if (byp && out_ready) exp_log.push_back(in_id);
    if (pop || drop) void'(mq.pop_front());
    if (push && !(byp && out_ready)) begin
      dup = 1'b0;
      foreach (mq[k]) if (mq[k].id == in_id) dup = 1'b1;
      assert (!dup) else $error("duplicate in-queue ID %0d issued", in_id);
      e.instr = in_instr;
      e.id    = in_id;
      e.rs1   = in_rs1;
      e.rs2   = in_rs2;
      e.state = PENDING;
      mq.push_back(e);
    end
    if (commit_valid) begin
      foreach (mq[k]) begin
        if (mq[k].state == PENDING && mq[k].id == commit_id)
          mq[k].state = commit_kill ? KILLED : COMMITTED;
      end
    end
  endtask

  // One clock: log a DUT dispatch, advance the model at the edge, return at negedge.
  task automatic tick();
    #1;
    if (out_valid && out_ready) dut_log.push_back(out_id);
    @(posedge ck);
    model_step();
    @(negedge ck);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_instr = '0; in_id = '0; in_rs1 = '0; in_rs2 = '0;
    commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    dut_log.delete();
    exp_log.delete();
  endtask

  task automatic push_id(input int id);
    in_valid = 1'b1;
    in_id    = 4'(id);
    in_instr = 32'h1000 + 32'(id);
    in_rs1   = $urandom;
    in_rs2   = $urandom;
  endtask

  function automatic logic [3:0] fresh_id();
    logic [3:0] c;
    bit clash;
    c = '0;
    for (int t = 0; t < 64; t++) begin
      c = 4'($urandom_range(15, 0));
      clash = 1'b0;
      foreach (mq[k]) if (mq[k].id == c) clash = 1'b1;
      if (!clash) return c;
    end
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_flags got empty=%b full=%b want 1/0", empty, full); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_rst got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    dut_log.delete();
    exp_log.delete();
  endtask

  task automatic test_full_commit();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      push_id(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (full !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL full_flags got full=%b in_ready=%b want 1/0", full, in_ready); end
    checks++; if (out_valid !== 1'b0 || count !== 3'd4) begin errors++; $display("FAIL full_stall got out_valid=%b count=%0d want 0/4", out_valid, count); end
    commit_valid = 1'b1; commit_id = 4'd1; commit_kill = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL commit_same_cycle got %b want 0", out_valid); end
    tick();
    commit_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_id !== 4'd1 || out_instr !== 32'h1001) begin
      errors++; $display("FAIL commit_latency got valid=%b id=%0d instr=%h want 1/1/00001001", out_valid, out_id, out_instr);
    end
  endtask

  // Continues from test_full_commit: queue holds 1 (committed), 2, 3, 4 (pending).
  task automatic test_commit_order();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    commit_valid = 1'b1; commit_id = 4'd3;
    tick();
    commit_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 3'd3) begin errors++; $display("FAIL order_stall got valid=%b count=%0d want 0/3", out_valid, count); end
    commit_valid = 1'b1; commit_id = 4'd2;
    tick();
    commit_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_id !== 4'd2) begin errors++; $display("FAIL order_first got valid=%b id=%0d want 1/2", out_valid, out_id); end
    out_ready = 1'b1;
    tick();
    #1;
    checks++; if (out_valid !== 1'b1 || out_id !== 4'd3) begin errors++; $display("FAIL order_second got valid=%b id=%0d want 1/3", out_valid, out_id); end
    tick();
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL order_tail got valid=%b count=%0d want 0/1", out_valid, count); end
    checks++; if (dut_log.size() != 3 || dut_log[0] != 4'd1 || dut_log[1] != 4'd2 || dut_log[2] != 4'd3) begin
      errors++; $display("FAIL order_log got %p want 1,2,3", dut_log);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_kill_drop();
    do_reset();
    push_id(5); tick();
    push_id(6); tick();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL kill_count2 got %0d want 2", count); end
    commit_valid = 1'b1; commit_id = 4'd5; commit_kill = 1'b1;
    tick();
    commit_id = 4'd6; commit_kill = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 3'd2) begin errors++; $display("FAIL kill_head got valid=%b count=%0d want 0/2", out_valid, count); end
    tick();
    commit_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd1 || out_valid !== 1'b1 || out_id !== 4'd6) begin
      errors++; $display("FAIL kill_next got count=%0d valid=%b id=%0d want 1/1/6", count, out_valid, out_id);
    end
    out_ready = 1'b1;
    tick();
    #1;
    checks++; if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL kill_drain got count=%0d empty=%b valid=%b want 0/1/0", count, empty, out_valid);
    end
    checks++; if (dut_log.size() != 1 || dut_log[0] != 4'd6) begin errors++; $display("FAIL kill_log got %p want 6", dut_log); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int next, cyc;
    bit acc;
    do_reset();
    next = 1;
    cyc  = 0;
    while (dut_log.size() < 10 && cyc < 80) begin
      if (next <= 10) push_id(next); else in_valid = 1'b0;
      commit_valid = in_valid; commit_id = in_id; commit_kill = 1'b0;
      out_ready = (cyc % 2 == 0);
      #1;
      checks++; if (count > 3'd4) begin errors++; $display("FAIL wrap_count got %0d want <=4", count); end
      acc = in_valid && in_ready;
      tick();
      if (acc) next++;
      cyc++;
    end
    idle();
    checks++; if (dut_log.size() != 10) begin errors++; $display("FAIL wrap_budget got %0d dispatches want 10", dut_log.size()); end
    for (int i = 0; i < dut_log.size() && i < 10; i++) begin
      checks++; if (dut_log[i] != 4'(i + 1)) begin errors++; $display("FAIL wrap_order slot %0d got %0d want %0d", i, dut_log[i], i + 1); end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    push_id(1); commit_valid = 1'b1; commit_id = 4'd1; tick();
    commit_valid = 1'b0;
    push_id(2); tick();
    push_id(3); tick();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got count=%0d valid=%b want 3/1", count, out_valid); end
    rst = 1'b1;
    push_id(9); commit_valid = 1'b1; commit_id = 4'd2; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst got valid=%b in_ready=%b want 0/0", out_valid, in_ready); end
    tick();
    rst = 1'b0;
    idle();
    out_ready = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || empty !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_after got count=%0d valid=%b empty=%b in_ready=%b want 0/0/1/1", count, out_valid, empty, in_ready);
    end
    tick();
    #1;
    checks++; if (dut_log.size() != 0 || count !== 3'd0) begin errors++; $display("FAIL mid_nodispatch got %0d dispatches count=%0d want 0/0", dut_log.size(), count); end
    out_ready = 1'b0;
  endtask

  task automatic test_bypass();
    do_reset();
    push_id(7); commit_valid = 1'b1; commit_id = 4'd7; commit_kill = 1'b0; out_ready = 1'b1;
    #1;
    if (BYP) begin
      checks++; if (out_valid !== 1'b1 || out_id !== 4'd7) begin errors++; $display("FAIL byp_same got valid=%b id=%0d want 1/7", out_valid, out_id); end
      tick();
      idle();
      #1;
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL byp_after got count=%0d valid=%b want 0/0", count, out_valid); end
    end else begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nobyp_same got valid=%b want 0", out_valid); end
      tick();
      idle();
      #1;
      checks++; if (out_valid !== 1'b1 || out_id !== 4'd7 || count !== 3'd1) begin
        errors++; $display("FAIL nobyp_next got valid=%b id=%0d count=%0d want 1/7/1", out_valid, out_id, count);
      end
      out_ready = 1'b1;
      tick();
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL nobyp_drain got count=%0d want 0", count); end
    end
    checks++; if (dut_log.size() != 1 || dut_log[0] != 4'd7) begin errors++; $display("FAIL byp_log got %p want 7", dut_log); end
    idle();
  endtask

  task automatic test_random();
    bit exp_byp, exp_valid, exp_rdy;
    iq_entry_t h;
    int r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst          = ($urandom_range(63, 0) == 0);
      in_valid     = $urandom_range(1, 0);
      in_id        = fresh_id();
      in_instr     = $urandom;
      in_rs1       = $urandom;
      in_rs2       = $urandom;
      commit_valid = $urandom_range(1, 0);
      commit_kill  = ($urandom_range(3, 0) == 0);
      r = $urandom_range(3, 0);
      if (r == 0 || mq.size() == 0) commit_id = 4'($urandom_range(15, 0));
      else if (r == 1) commit_id = in_id;
      else commit_id = mq[$urandom_range(mq.size() - 1, 0)].id;
      out_ready = $urandom_range(1, 0);
      #1;
      exp_byp   = BYP && !rst && (mq.size() == 0) && in_valid && commit_valid &&
                  (commit_id == in_id) && !commit_kill;
      exp_valid = !rst && (((mq.size() > 0) && (mq[0].state == COMMITTED)) || exp_byp);
      exp_rdy   = !rst && (mq.size() < DEPTH);
      checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, out_valid, exp_valid); end
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, in_ready, exp_rdy); end
      checks++; if (count !== 3'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
        errors++; $display("FAIL rnd_status cyc %0d got count=%0d empty=%b full=%b want count=%0d", c, count, empty, full, mq.size());
      end
      if (exp_valid) begin
        if (exp_byp) begin
          h.id = in_id; h.instr = in_instr; h.rs1 = in_rs1; h.rs2 = in_rs2;
        end else begin
          h = mq[0];
        end
        checks++; if (out_id !== h.id || out_instr !== h.instr || out_rs1 !== h.rs1 || out_rs2 !== h.rs2) begin
          errors++; $display("FAIL rnd_payload cyc %0d got id=%0d instr=%h want id=%0d instr=%h", c, out_id, out_instr, h.id, h.instr);
        end
      end
      tick();
    end
    rst = 1'b0;
    idle();
    checks++; if (dut_log.size() != exp_log.size()) begin errors++; $display("FAIL rnd_log_len got %0d want %0d", dut_log.size(), exp_log.size()); end
    for (int i = 0; i < dut_log.size() && i < exp_log.size(); i++) begin
      checks++; if (dut_log[i] != exp_log[i]) begin errors++; $display("FAIL rnd_log slot %0d got %0d want %0d", i, dut_log[i], exp_log[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge ck);
    test_reset();
    test_full_commit();
    test_commit_order();
    test_kill_drop();
    test_wrap();
    test_reset_midflight();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
